// File: rtl/ss_seq_pkg.sv
// Shared definitions for the savestate bus sequencer: allocation mask, FSM states
// and the checksum word offset (used when SS_CHECKSUM_EN is defined).
package ss_seq_pkg;

  localparam int unsigned SS_NUM_IDX = 64;

  // Allocated indices: 0-2, 4-12, 16-19, 24, 28, 32-37, 40, 48-52.
  localparam logic [63:0] SS_IDX_VALID = 64'h001F_013F_110F_1FF7;

  // Checksum word lives directly after the last index slot.
  localparam int unsigned SS_CHK_OFFSET = SS_NUM_IDX;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SAVE_ADR,
    ST_SAVE_CAP,
    ST_SAVE_MEM,
    ST_LOAD_RST,
    ST_LOAD_MEM,
    ST_LOAD_BUS,
    ST_CHK,
    ST_FIN
  } ss_state_e;

  function automatic logic idx_allocated(input int unsigned idx);
    if (idx >= 64) return 1'b0;
    return SS_IDX_VALID[idx[5:0]];
  endfunction

endpackage

// File: rtl/ss_idx_next.sv
// Combinational priority search: lowest allocated index above cur_i (or equal to
// it when incl_i is set) inside 0..NUM_IDX-1; last_o flags that none remains.
module ss_idx_next
  import ss_seq_pkg::*;
#(
  parameter int unsigned NUM_IDX = SS_NUM_IDX
) (
  input  logic [9:0] cur_i,
  input  logic       incl_i,
  output logic [9:0] next_o,
  output logic       last_o
);

  always_comb begin
    next_o = '0;
    last_o = 1'b1;
    // Scan downward so the final hit is the lowest qualifying index.
    for (int j = int'(NUM_IDX) - 1; j >= 0; j--) begin
      if (idx_allocated(unsigned'(j)) &&
          ((j > int'(cur_i)) || (incl_i && (j == int'(cur_i))))) begin
        next_o = 10'(j);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ss_bus_sequencer.sv
// Walks the allocated savestate bus indices to save bus registers to memory or
// restore them from memory. Define SS_CHECKSUM_EN to add the XOR checksum word.
module ss_bus_sequencer
  import ss_seq_pkg::*;
#(
  parameter int unsigned NUM_IDX  = SS_NUM_IDX,
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned MEM_BASE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic              load_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [9:0]        ss_adr,
  output logic [63:0]       ss_din,
  output logic              ss_wren,
  output logic              ss_rst,
  input  logic [63:0]       ss_dout,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic [3:0]        dbg_state
);

  localparam logic [MEM_AW-1:0] BASE_ADDR = MEM_AW'(MEM_BASE);

`ifdef SS_CHECKSUM_EN
  localparam logic [MEM_AW-1:0] CHK_ADDR = MEM_AW'(MEM_BASE + NUM_IDX);
  localparam ss_state_e ST_END = ST_CHK;
`else
  localparam ss_state_e ST_END = ST_FIN;
`endif

  ss_state_e   state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [63:0] data_q, data_d;

`ifdef SS_CHECKSUM_EN
  logic [63:0] csum_q, csum_d;
  logic        error_q, error_d;
  logic        save_q, save_d;
  logic        arm_q, arm_d;
`endif

  logic [9:0] srch_cur, srch_next;
  logic       srch_incl, srch_last;

  // From IDLE and LOAD_RST the search starts at index 0 inclusive.
  assign srch_incl = (state_q == ST_IDLE) || (state_q == ST_LOAD_RST);
  assign srch_cur  = srch_incl ? 10'd0 : idx_q;

  ss_idx_next #(.NUM_IDX(NUM_IDX)) u_idx_next (
    .cur_i  (srch_cur),
    .incl_i (srch_incl),
    .next_o (srch_next),
    .last_o (srch_last)
  );

  assign ss_adr    = idx_q;
  assign ss_din    = data_q;
  assign dbg_state = state_q;

`ifdef SS_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
`ifdef SS_CHECKSUM_EN
    csum_d    = csum_q;
    error_d   = error_q;
    save_d    = save_q;
    arm_d     = arm_q;
`endif
    busy      = 1'b1;
    done      = 1'b0;
    ss_wren   = 1'b0;
    ss_rst    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = BASE_ADDR + MEM_AW'(idx_q);
    mem_wdata = data_q;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (save_req || load_req) begin
`ifdef SS_CHECKSUM_EN
          csum_d  = '0;
          error_d = 1'b0;
          save_d  = save_req;
`endif
          if (save_req) begin
            idx_d   = srch_next;
            state_d = srch_last ? ST_END : ST_SAVE_ADR;
          end else begin
            state_d = ST_LOAD_RST;
          end
        end
      end
      ST_SAVE_ADR: state_d = ST_SAVE_CAP;
      ST_SAVE_CAP: begin
        data_d  = ss_dout;
`ifdef SS_CHECKSUM_EN
        csum_d  = csum_q ^ ss_dout;
`endif
        state_d = ST_SAVE_MEM;
      end
      ST_SAVE_MEM: begin
        mem_we = 1'b1;
        if (mem_ack) begin
          idx_d   = srch_last ? idx_q : srch_next;
          state_d = srch_last ? ST_END : ST_SAVE_ADR;
        end
      end
      ST_LOAD_RST: begin
        ss_rst  = 1'b1;
        idx_d   = srch_next;
        state_d = srch_last ? ST_END : ST_LOAD_MEM;
      end
      ST_LOAD_MEM: begin
        mem_re = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
`ifdef SS_CHECKSUM_EN
          csum_d  = csum_q ^ mem_rdata;
`endif
          state_d = ST_LOAD_BUS;
        end
      end
      ST_LOAD_BUS: begin
        ss_wren = 1'b1;
        idx_d   = srch_last ? idx_q : srch_next;
        state_d = srch_last ? ST_END : ST_LOAD_MEM;
      end
`ifdef SS_CHECKSUM_EN
      // One quiet cycle first so the memory request always drops after an ack.
      ST_CHK: begin
        mem_addr  = CHK_ADDR;
        mem_wdata = csum_q;
        arm_d     = 1'b1;
        if (arm_q) begin
          mem_we = save_q;
          mem_re = !save_q;
          if (mem_ack) begin
            if (!save_q) error_d = (mem_rdata != csum_q);
            arm_d   = 1'b0;
            state_d = ST_FIN;
          end
        end
      end
`endif
      ST_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef SS_CHECKSUM_EN
      csum_q  <= '0;
      error_q <= 1'b0;
      save_q  <= 1'b0;
      arm_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
`ifdef SS_CHECKSUM_EN
      csum_q  <= csum_d;
      error_q <= error_d;
      save_q  <= save_d;
      arm_q   <= arm_d;
`endif
    end
  end

endmodule
